// File: rtl/csa_pkg.sv
// csa_pkg: shared widths, result flags and saturation limits for the carry-select subtractor
package csa_pkg;
  localparam int CSA_WIDTH = 32;
  localparam int CSA_SPLIT = 16;
  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
  } csa_flags_t;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/csel_sub_block.sv
// csel_sub_block: ripple-borrow subtractor d = a - b - bin over W bits
module csel_sub_block #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         bin_i,
  output logic [W-1:0] d_o,
  output logic         bout_o
);
  logic br;
  // Ripple the borrow from LSB to MSB; the final borrow is the block's borrow out.
  always_comb begin
    br = bin_i;
    d_o = '0;
    for (int i = 0; i < W; i++) begin
      d_o[i] = a_i[i] ^ b_i[i] ^ br;
      br = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br);
    end
    bout_o = br;
  end
endmodule

// File: rtl/csa_sub_pipe.sv
// csa_sub_pipe: two-stage carry-select subtractor Diff = A - B - Bin with flags; CSA_SUB_SAT_EN saturates on overflow
module csa_sub_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int SPLIT = CSA_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int HW = WIDTH - SPLIT;
`ifdef CSA_SUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));
`endif
  logic             s1_valid_q, s2_valid_q, s1_load, s2_load;
  logic [SPLIT-1:0] lo_d, lo_q;
  logic             bl_d, bl_q;
  logic [HW-1:0]    hi0_d, hi0_q, hi1_d, hi1_q;
  logic             hb0_d, hb0_q, hb1_d, hb1_q;
  logic             am_q, bm_q;
  logic [WIDTH-1:0] raw, diff_d, diff_q;
  csa_flags_t       flags_d, flags_q;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  csel_sub_block #(.W(SPLIT)) u_lo (
    .a_i(A[SPLIT-1:0]), .b_i(B[SPLIT-1:0]), .bin_i(Bin), .d_o(lo_d), .bout_o(bl_d)
  );
  csel_sub_block #(.W(HW)) u_hi0 (
    .a_i(A[WIDTH-1:SPLIT]), .b_i(B[WIDTH-1:SPLIT]), .bin_i(1'b0), .d_o(hi0_d), .bout_o(hb0_d)
  );
  csel_sub_block #(.W(HW)) u_hi1 (
    .a_i(A[WIDTH-1:SPLIT]), .b_i(B[WIDTH-1:SPLIT]), .bin_i(1'b1), .d_o(hi1_d), .bout_o(hb1_d)
  );

  // Stage 1: capture the resolved low half and both speculative upper halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      lo_q <= '0;
      bl_q <= 1'b0;
      hi0_q <= '0;
      hi1_q <= '0;
      hb0_q <= 1'b0;
      hb1_q <= 1'b0;
      am_q <= 1'b0;
      bm_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        lo_q <= lo_d;
        bl_q <= bl_d;
        hi0_q <= hi0_d;
        hi1_q <= hi1_d;
        hb0_q <= hb0_d;
        hb1_q <= hb1_d;
        am_q <= A[WIDTH-1];
        bm_q <= B[WIDTH-1];
      end
    end
  end

  // Stage 2 combinational: the low borrow picks the upper candidate, then flags and optional clamp.
  always_comb begin
    raw = {bl_q ? hi1_q : hi0_q, lo_q};
    flags_d = '0;
    flags_d.bout = bl_q ? hb1_q : hb0_q;
    flags_d.ovf = (am_q != bm_q) && (raw[WIDTH-1] != am_q);
`ifdef CSA_SUB_SAT_EN
    diff_d = flags_d.ovf ? (am_q ? SMIN : SMAX) : raw;
`else
    diff_d = raw;
`endif
    flags_d.zero = ~|diff_d;
  end

  // Stage 2 register: outputs hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      diff_q <= '0;
      flags_q <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        diff_q <= diff_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign Diff      = diff_q;
  assign Bout      = flags_q.bout;
  assign Ovf       = flags_q.ovf;
  assign Zero      = flags_q.zero;
endmodule

// File: tb/tb_csa_sub_pipe.sv
// tb_csa_sub_pipe: directed and randomized checks of csa_sub_pipe against an arithmetic reference model
module tb_csa_sub_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, Bin, Bout, Ovf, Zero;
  logic [31:0] A, B, Diff;

  typedef struct packed {
    logic [31:0] d;
    logic bo;
    logic ov;
    logic z;
  } res_t;

  res_t exp_q[$];
  res_t prev, e;
  bit held = 0;
  bit acc;
  int checks = 0;
  int errors = 0;

`ifdef CSA_SUB_SAT_EN
  localparam logic [31:0] OVF_DIFF = 32'h80000000;
`else
  localparam logic [31:0] OVF_DIFF = 32'h7FFFFFFF;
`endif

  csa_sub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Zero(Zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    res_t r;
    longint sd;
    sd = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    r.d = a - b - 32'(bin);
    r.ov = longint'($signed(r.d)) != sd;
    r.bo = {32'b0, a} < ({32'b0, b} + 64'(bin));
`ifdef CSA_SUB_SAT_EN
    if (r.ov) r.d = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    r.z = (r.d == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin);
    bit ok = 0;
    A = a;
    B = b;
    Bin = bin;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL accept_timeout observed=in_ready_low expected=accept a=%h b=%h", a, b);
    end
    if (ok) exp_q.push_back(model(a, b, bin));
  endtask

  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin,
                     input logic [31:0] ed, input logic ebo, input logic eov, input logic ez);
    send(a, b, bin);
    @(negedge clk);
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_diff"}, Diff, ed);
    chk({tag, "_flags"}, {29'b0, Bout, Ovf, Zero}, {29'b0, ebo, eov, ez});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: scoreboard on every output transfer, stability while stalled.
  always @(negedge clk) begin
    if (rst || !out_valid) begin
      if (held && !rst) chk("hold_valid", 32'(out_valid), 32'd1);
      held = 0;
    end else begin
      if (held) begin
        chk("hold_diff", Diff, prev.d);
        chk("hold_flags", {29'b0, Bout, Ovf, Zero}, {29'b0, prev.bo, prev.ov, prev.z});
      end
      if (out_ready) begin
        held = 0;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out observed=%h expected=no_output", Diff);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_diff", Diff, e.d);
          chk("sb_flags", {29'b0, Bout, Ovf, Zero}, {29'b0, e.bo, e.ov, e.z});
        end
      end else begin
        held = 1;
        prev = '{Diff, Bout, Ovf, Zero};
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_diff", Diff, 32'd0);
    chk("rst_flags", {29'b0, Bout, Ovf, Zero}, 32'd0);
    @(posedge clk);
    #1;
    dir("sub5_3", 32'd5, 32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
    dir("sub0_1", 32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    dir("sub7_7", 32'd7, 32'd7, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    dir("split", 32'h00010000, 32'd0, 1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    dir("ovf", 32'h80000000, 32'd1, 1'b0, OVF_DIFF, 1'b0, 1'b1, 1'b0);
    dir("bin_eq", 32'h00001234, 32'h00001234, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    send(32'd10, 32'd1, 1'b0);
    send(32'd20, 32'd2, 1'b0);
    A = 32'd30;
    B = 32'd3;
    Bin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'd30, 32'd3, 1'b0);
    send(32'd40, 32'd4, 1'b0);
    drain();
    out_ready = 1'b0;
    send(32'd50, 32'd5, 1'b0);
    send(32'd60, 32'd6, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", Diff, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_dropped", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    dir("post_rst", 32'd3, 32'd3, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 800; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        A = rnd();
        B = ($urandom_range(0, 7) == 0) ? A : rnd();
        Bin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(model(A, B, Bin));
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
